// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Writeback arbiter feeding the ROB result write port. ALU and LSB results
//   are queued in per-source FIFOs and granted round-robin, so at most one
//   (rob_idx, value) pair leaves per cycle. Pending results are flushed on
//   branch roll-back.
// Ports
//   clk, rst_in          clock, synchronous active-high reset
//   rdy_in               global ready; all state frozen while low
//   roll_back            mispredict flush (clears both queues, kills output)
//   alu_in_en/_rob_idx_in/_val_in, alu_full   ALU result in, ALU queue full
//   lsb_in_en/_rob_idx_in/_val_in, lsb_full   LSB result in, LSB queue full
//   cdb_out_en/_rob_idx_out/_val_out/_src_out registered writeback (src 0=ALU 1=LSB)
module wb_arbiter #(
  parameter int ROB_IDX_BITS = 4,
  parameter int DATA_BITS    = 32,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    roll_back,
  input  logic                    alu_in_en,
  input  logic [ROB_IDX_BITS-1:0] alu_rob_idx_in,
  input  logic [DATA_BITS-1:0]    alu_val_in,
  output logic                    alu_full,
  input  logic                    lsb_in_en,
  input  logic [ROB_IDX_BITS-1:0] lsb_rob_idx_in,
  input  logic [DATA_BITS-1:0]    lsb_val_in,
  output logic                    lsb_full,
  output logic                    cdb_out_en,
  output logic [ROB_IDX_BITS-1:0] cdb_rob_idx_out,
  output logic [DATA_BITS-1:0]    cdb_val_out,
  output logic                    cdb_src_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ROB_IDX_BITS-1:0] idx;
    logic [DATA_BITS-1:0]    val;
  } res_t;

  // Index 0 = ALU, 1 = LSB throughout.
  res_t [1:0] req;
  logic [1:0] req_en;
  logic [1:0] full, nempty, cand, grant, push, pop;
  res_t [1:0] cand_data;
  logic       rr_q;
  logic       win, any_cand;
  logic       adv;   // state may advance this cycle (ready, no flush)

  assign req[0]    = {alu_rob_idx_in, alu_val_in};
  assign req[1]    = {lsb_rob_idx_in, lsb_val_in};
  assign req_en    = {lsb_in_en, alu_in_en};
  assign adv       = rdy_in & ~roll_back;
  assign any_cand  = |cand;
  // Contention goes to the source that did not win last; otherwise the lone
  // candidate wins (cand[1] selects LSB when it is the only one).
  assign win       = (&cand) ? ~rr_q : cand[1];
  assign alu_full  = full[0];
  assign lsb_full  = full[1];

  for (genvar s = 0; s < 2; s++) begin : g_src
    localparam bit SID = (s == 1);
    res_t             mem_q [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    cnt_q;

    assign full[s]      = (cnt_q == CW'(DEPTH));
    assign nempty[s]    = (cnt_q != '0);
    // Queued data always goes ahead of a new request from the same source.
    assign cand[s]      = nempty[s] | req_en[s];
    assign cand_data[s] = nempty[s] ? mem_q[head_q] : req[s];
    assign grant[s]     = any_cand & (win == SID);
    assign pop[s]       = grant[s] & nempty[s];
    // A request granted straight through the bypass never touches the FIFO.
    assign push[s]      = req_en[s] & ~full[s] & ~(grant[s] & ~nempty[s]);

    always_ff @(posedge clk) begin
      if (!rst_in && adv && push[s]) mem_q[tail_q] <= req[s];
    end

    always_ff @(posedge clk) begin
      if (rst_in) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else if (rdy_in) begin
        if (roll_back) begin
          head_q <= '0;
          tail_q <= '0;
          cnt_q  <= '0;
        end else begin
          if (push[s]) tail_q <= tail_q + PW'(1);
          if (pop[s])  head_q <= head_q + PW'(1);
          cnt_q <= cnt_q + CW'(push[s]) - CW'(pop[s]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      rr_q            <= 1'b0;
      cdb_out_en      <= 1'b0;
      cdb_rob_idx_out <= '0;
      cdb_val_out     <= '0;
      cdb_src_out     <= 1'b0;
    end else if (rdy_in) begin
      if (roll_back) begin
        cdb_out_en <= 1'b0;   // rr pointer deliberately kept
      end else begin
        cdb_out_en <= any_cand;
        if (any_cand) begin
          rr_q            <= win;
          cdb_rob_idx_out <= cand_data[win].idx;
          cdb_val_out     <= cand_data[win].val;
          cdb_src_out     <= win;
        end
      end
    end
  end
endmodule
